recv_send_m_1ofn: RTL and testbench
===================================

Name: recv_send_m_1ofn

Overview:
- Clocked boundary adapter between asynchronous e1ofN four-phase channels and synchronous valid/ready RTL interfaces.
- Contains one receiver path (e1ofN in → RTL out) and one independent sender path (RTL in → e1ofN out).
- Sits in the wrapper of every RTL-bodied node, for example the 9-bit decoder of the NoC.

Parameters:
- M, 9: number of 1-of-N digits per channel token.
- N, 2: radix of each digit. Power of two, ≥2.
- B, derived clog2(N): bits per digit.
- W, derived M*B: RTL data width.

Ports:
- CLK  in  1  clock
- _RESET  in  1  asynchronous, active-low reset
- in_d  in  M*N  receive rails; digit i = in_d[i*N +: N]
- in_e  out  1  receive enable; high = ready for token, low = acknowledge
- rcv_data  out  W  decoded received token
- rcv_valid  out  1  rcv_data holds an unconsumed token
- rcv_ready  in  1  RTL consumer accepts token
- out_d  out  M*N  send rails, registered
- out_e  in  1  send enable from downstream
- snd_data  in  W  token to send
- snd_valid  in  1  RTL producer offers token
- snd_ready  out  1  sender accepts token this cycle

Behaviour:
- Reset (async, _RESET=0): in_e=0, rcv_valid=0, rcv_data=0, out_d=0, snd_ready=0. All synchronizers and FSMs are cleared.
- Synchronization: in_d and out_e each pass through a 2-flop synchronizer before any use.
- Receiver FSM:
  - R_IDLE: in_e=1. Leaves when every synchronized digit has ≥1 rail high (digit completion).
  - Decode: each digit value = index of its lowest set rail, placed at rcv_data[i*B +: B]. Digit 0 is least significant.
  - On the completion edge: capture rcv_data, set rcv_valid=1, set in_e=0, go to R_NEUTRAL.
  - R_NEUTRAL: wait until all synchronized rails are 0, then go to R_HOLD.
  - R_HOLD: wait for the buffer to empty, then in_e=1 and return to R_IDLE.
  - rcv_valid clears on the edge where rcv_valid && rcv_ready. rcv_data is held stable while rcv_valid=1.
  - in_e rises only when rails are neutral AND rcv_valid=0, so there is one token of buffering.
  - Latency: rcv_valid rises on the 3rd CLK edge after the last rail rises (2 sync + 1 capture). in_e falls on that same edge.
  - If all rails return to 0 before completion, no token is produced.
  - Bursts of rails are monotonic; a partial set of digits never produces a token.
  - Out of reset: in_e goes to 1 on the first edge where synchronized rails are neutral.
- Sender FSM:
  - S_IDLE: snd_ready = synchronized out_e. On snd_valid && snd_ready, register the encoding of snd_data on out_d: digit i drives rail snd_data[i*B +: B], all others 0. Go to S_ACK.
  - S_ACK: out_d held. When synchronized out_e = 0, clear out_d to 0 on that edge and go to S_REN.
  - S_REN: out_d=0. When synchronized out_e = 1, go to S_IDLE.
  - snd_ready is 0 in every state except S_IDLE. snd_ready never asserts while out_d is non-zero.
  - Rails rise together on one edge (glitch-free, single-flop outputs).
  - Reset mid-operation: out_d drops to 0 immediately.
- The two paths are fully independent. Simultaneous receive and send activity is supported each cycle.
- Exactly one token per four-phase cycle on each side.
- Each RTL handshake transfers exactly one token.

Test Plan:
- Reset: hold _RESET=0 with random rails → in_e=0, out_d=0, rcv_valid=0, snd_ready=0. Release with rails 0 → in_e=1 within 3 cycles.
- Receive M=9,N=2: drive rails for 9'h1A5, rcv_ready=0 → rcv_valid=1 with rcv_data=9'h1A5 on 3rd edge, in_e=0. Rails to 0 → in_e stays 0. Pulse rcv_ready → rcv_valid=0, then in_e=1.
- Back-pressure: two tokens 9'h001 then 9'h1FF with rcv_ready=0 → second token is not acknowledged until the first is consumed. Data order is preserved.
- Send M=9,N=2: out_e=1, snd_valid=1, snd_data=9'h0F3 → snd_ready=1 for one accept. out_d has rail1 high for bits 0,1,4,5,6,7 and rail0 high for others. out_e=0 → out_d=0. out_e=1 → snd_ready=1 again.
- Radix-4 (M=1,N=4): send snd_data=2'd2 → out_d=4'b0100. Receive in_d=4'b1000 → rcv_data=2'd3.
- Concurrent stress: random handshake delays on both sides, 1000 tokens each → all tokens delivered intact and in order, with no rail asserted while its e is low at the start of a cycle.

Source files
------------

// File: rtl/recv_send_m_1ofn.sv
// e1ofN four-phase <-> valid/ready adapter: receive path buffers one token, rcv_valid 3 edges after last rail;
// send path registers rails one edge after accept; in_e is withheld while a token waits, snd_ready only when idle.
module recv_send_m_1ofn #(
  parameter int M = 9,
  parameter int N = 2,
  localparam int B = $clog2(N),
  localparam int W = M * B
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [M*N-1:0] in_d,
  output logic           in_e,
  output logic [W-1:0]   rcv_data,
  output logic           rcv_valid,
  input  logic           rcv_ready,
  output logic [M*N-1:0] out_d,
  input  logic           out_e,
  input  logic [W-1:0]   snd_data,
  input  logic           snd_valid,
  output logic           snd_ready
);

  typedef enum logic [1:0] {R_IDLE, R_NEUTRAL, R_HOLD} r_state_t;
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_REN} s_state_t;

  r_state_t r_state;
  s_state_t s_state;

  logic [M*N-1:0] in_s1, in_s2;
  logic           oe_s1, oe_s2;
  logic           complete, neutral;
  logic [W-1:0]   dec;
  logic [M*N-1:0] enc;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      in_s1 <= '0;
      in_s2 <= '0;
      oe_s1 <= 1'b0;
      oe_s2 <= 1'b0;
    end else begin
      in_s1 <= in_d;
      in_s2 <= in_s1;
      oe_s1 <= out_e;
      oe_s2 <= oe_s1;
    end
  end

  // Lowest set rail wins, so the downward loop lets lower indices overwrite higher ones.
  always_comb begin
    complete = 1'b1;
    neutral  = (in_s2 == '0);
    dec      = '0;
    for (int i = 0; i < M; i++) begin
      if (in_s2[i*N +: N] == '0)
        complete = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
        if (in_s2[i*N + j])
          dec[i*B +: B] = B'(j);
      end
    end
  end

  always_comb begin
    enc = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        if (snd_data[i*B +: B] == B'(j))
          enc[i*N + j] = 1'b1;
      end
    end
  end

  // Starts in R_HOLD so in_e rises as soon as the synchronized rails read neutral.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_state   <= R_HOLD;
      in_e      <= 1'b0;
      rcv_valid <= 1'b0;
      rcv_data  <= '0;
    end else begin
      if (rcv_valid && rcv_ready)
        rcv_valid <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (complete) begin
            rcv_data  <= dec;
            rcv_valid <= 1'b1;
            in_e      <= 1'b0;
            r_state   <= R_NEUTRAL;
          end
        end
        R_NEUTRAL: begin
          if (neutral)
            r_state <= R_HOLD;
        end
        R_HOLD: begin
          if (neutral && !rcv_valid) begin
            in_e    <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_HOLD;
      endcase
    end
  end

  assign snd_ready = (s_state == S_IDLE) && oe_s2;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      s_state <= S_IDLE;
      out_d   <= '0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (snd_valid && snd_ready) begin
            out_d   <= enc;
            s_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!oe_s2) begin
            out_d   <= '0;
            s_state <= S_REN;
          end
        end
        S_REN: begin
          if (oe_s2)
            s_state <= S_IDLE;
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_send_m_1ofn.sv
// Bench for recv_send_m_1ofn: directed M=9/N=2 and M=1/N=4 steps, then randomized concurrent traffic
// checked against in-order token queues and the four-phase protocol rules.
module tb_recv_send_m_1ofn;

  localparam int NTOK   = 1000;
  localparam int BUDGET = 60000;

  logic        CLK;
  logic        _RESET;
  logic [17:0] in_d, out_d;
  logic        in_e, rcv_valid, rcv_ready, out_e, snd_valid, snd_ready;
  logic [8:0]  rcv_data, snd_data;
  logic [3:0]  in_d4, out_d4;
  logic        in_e4, rcv_valid4, rcv_ready4, out_e4, snd_valid4, snd_ready4;
  logic [1:0]  rcv_data4, snd_data4;

  int checks = 0;
  int errors = 0;
  int rx_got = 0;
  int tx_got = 0;
  int done_cnt = 0;
  bit abort = 0;
  logic [8:0] rx_q[$];
  logic [8:0] tx_q[$];
  logic [8:0] rx_tok, tx_tok;
  logic [9:0] tx_dec;
  logic       rr;
  logic [17:0] prev_out_d;
  logic        prev_out_e, prev_in_e, prev_rcv_valid;

  recv_send_m_1ofn #(.M(9), .N(2)) u9 (
    .CLK(CLK), ._RESET(_RESET),
    .in_d(in_d), .in_e(in_e), .rcv_data(rcv_data), .rcv_valid(rcv_valid), .rcv_ready(rcv_ready),
    .out_d(out_d), .out_e(out_e), .snd_data(snd_data), .snd_valid(snd_valid), .snd_ready(snd_ready)
  );

  recv_send_m_1ofn #(.M(1), .N(4)) u4 (
    .CLK(CLK), ._RESET(_RESET),
    .in_d(in_d4), .in_e(in_e4), .rcv_data(rcv_data4), .rcv_valid(rcv_valid4), .rcv_ready(rcv_ready4),
    .out_d(out_d4), .out_e(out_e4), .snd_data(snd_data4), .snd_valid(snd_valid4), .snd_ready(snd_ready4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Dual-rail code: bit value v of digit i raises rail 2*i+v.
  function automatic logic [17:0] enc9(input logic [8:0] v);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) r[2*i+1] = 1'b1;
      else      r[2*i]   = 1'b1;
    end
    return r;
  endfunction

  // Returns {code_ok, value}; code_ok drops if any digit is not exactly one-hot.
  function automatic logic [9:0] dec9(input logic [17:0] d);
    logic [8:0] v;
    logic       ok;
    v  = '0;
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      case (d[2*i +: 2])
        2'b01:   v[i] = 1'b0;
        2'b10:   v[i] = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return {ok, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    _RESET = 1'b0;
    in_d = 18'($urandom); in_d4 = 4'($urandom);
    out_e = 1'($urandom); out_e4 = 1'($urandom);
    rcv_ready = 1'b0; rcv_ready4 = 1'b0;
    snd_valid = 1'b0; snd_valid4 = 1'b0;
    snd_data = 9'($urandom); snd_data4 = 2'($urandom);
    repeat (4) @(negedge CLK);
    chk("rst_in_e", in_e, 0);
    chk("rst_rcv_valid", rcv_valid, 0);
    chk("rst_rcv_data", rcv_data, 0);
    chk("rst_out_d", out_d, 0);
    chk("rst_snd_ready", snd_ready, 0);
    chk("rst_out_d4", out_d4, 0);
    chk("rst_in_e4", in_e4, 0);

    in_d = '0; in_d4 = '0; out_e = 1'b0; out_e4 = 1'b0;
    @(negedge CLK);
    _RESET = 1'b1;
    for (int k = 0; k < 3 && in_e !== 1'b1; k++) @(negedge CLK);
    chk("rst_release_in_e", in_e, 1);

    // Receive latency: token appears on the third edge after the rails
    in_d = enc9(9'h1A5);
    @(negedge CLK); @(negedge CLK);
    chk("rx_before_3rd_edge", rcv_valid, 0);
    @(negedge CLK);
    chk("rx_valid_3rd_edge", rcv_valid, 1);
    chk("rx_data_1a5", rcv_data, 9'h1A5);
    chk("rx_in_e_ack", in_e, 0);
    in_d = '0;
    repeat (6) @(negedge CLK);
    chk("rx_in_e_held_low", in_e, 0);
    chk("rx_data_held", rcv_data, 9'h1A5);
    rcv_ready = 1'b1;
    @(negedge CLK);
    rcv_ready = 1'b0;
    chk("rx_consumed", rcv_valid, 0);
    for (int k = 0; k < 4 && in_e !== 1'b1; k++) @(negedge CLK);
    chk("rx_in_e_reenable", in_e, 1);

    // Back-pressure: the second token must wait for the first to be consumed
    in_d = enc9(9'h001);
    for (int k = 0; k < 6 && rcv_valid !== 1'b1; k++) @(negedge CLK);
    chk("bp_first_valid", rcv_valid, 1);
    in_d = '0;
    repeat (10) @(negedge CLK);
    chk("bp_in_e_withheld", in_e, 0);
    chk("bp_first_data", rcv_data, 9'h001);
    rcv_ready = 1'b1;
    @(negedge CLK);
    rcv_ready = 1'b0;
    for (int k = 0; k < 4 && in_e !== 1'b1; k++) @(negedge CLK);
    chk("bp_in_e_after_consume", in_e, 1);
    in_d = enc9(9'h1FF);
    for (int k = 0; k < 6 && rcv_valid !== 1'b1; k++) @(negedge CLK);
    chk("bp_second_valid", rcv_valid, 1);
    chk("bp_second_data", rcv_data, 9'h1FF);
    in_d = '0;
    rcv_ready = 1'b1;
    @(negedge CLK);
    rcv_ready = 1'b0;

    // Send 0x0F3: rail1 on bits 0,1,4,5,6,7 and rail0 on bits 2,3,8
    out_e = 1'b1;
    snd_data = 9'h0F3;
    snd_valid = 1'b1;
    for (int k = 0; k < 6 && snd_ready !== 1'b1; k++) @(negedge CLK);
    chk("tx_ready", snd_ready, 1);
    @(negedge CLK);
    snd_valid = 1'b0;
    chk("tx_rails_0f3", out_d, 18'h1AA5A);
    chk("tx_ready_drop", snd_ready, 0);
    out_e = 1'b0;
    for (int k = 0; k < 5 && out_d !== 18'h0; k++) @(negedge CLK);
    chk("tx_rails_reset", out_d, 0);
    chk("tx_ready_low_in_ren", snd_ready, 0);
    out_e = 1'b1;
    for (int k = 0; k < 5 && snd_ready !== 1'b1; k++) @(negedge CLK);
    chk("tx_ready_again", snd_ready, 1);

    // Radix-4 instance
    out_e4 = 1'b1;
    snd_data4 = 2'd2;
    snd_valid4 = 1'b1;
    for (int k = 0; k < 6 && snd_ready4 !== 1'b1; k++) @(negedge CLK);
    @(negedge CLK);
    snd_valid4 = 1'b0;
    chk("r4_tx_rails", out_d4, 4'b0100);
    in_d4 = 4'b1000;
    for (int k = 0; k < 6 && rcv_valid4 !== 1'b1; k++) @(negedge CLK);
    chk("r4_rx_valid", rcv_valid4, 1);
    chk("r4_rx_data", rcv_data4, 2'd3);
    in_d4 = '0;

    prev_out_d = out_d; prev_out_e = out_e; prev_in_e = in_e; prev_rcv_valid = rcv_valid;
    fork
      begin : rx_prod
        for (int t = 0; t < NTOK && !abort; t++) begin
          for (int k = 0; in_e !== 1'b1; k++) begin
            if (k > 400) begin abort = 1'b1; break; end
            @(negedge CLK);
          end
          if (abort) break;
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          rx_tok = 9'($urandom);
          rx_q.push_back(rx_tok);
          in_d = enc9(rx_tok);
          for (int k = 0; in_e !== 1'b0; k++) begin
            if (k > 400) begin abort = 1'b1; break; end
            @(negedge CLK);
          end
          if (abort) break;
          repeat ($urandom_range(0, 2)) @(negedge CLK);
          in_d = '0;
        end
        done_cnt++;
      end
      begin : rx_cons
        for (int c = 0; c < BUDGET && rx_got < NTOK && !abort; c++) begin
          @(negedge CLK);
          rr = 1'($urandom);
          rcv_ready = rr;
          if (rcv_valid === 1'b1 && rr) begin
            chk("stress_rx_data", rcv_data, (rx_q.size() != 0) ? 32'(rx_q.pop_front()) : 32'hDEAD);
            rx_got++;
          end
        end
        rcv_ready = 1'b0;
        if (rx_got < NTOK) abort = 1'b1;
        done_cnt++;
      end
      begin : tx_prod
        for (int t = 0; t < NTOK && !abort; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          tx_tok = 9'($urandom);
          tx_q.push_back(tx_tok);
          snd_data = tx_tok;
          snd_valid = 1'b1;
          for (int k = 0; snd_ready !== 1'b1; k++) begin
            if (k > 400) begin abort = 1'b1; break; end
            @(negedge CLK);
          end
          if (abort) break;
          @(negedge CLK);
          snd_valid = 1'b0;
          snd_data = 9'($urandom);
        end
        snd_valid = 1'b0;
        done_cnt++;
      end
      begin : tx_cons
        for (int t = 0; t < NTOK && !abort; t++) begin
          for (int k = 0; out_d === 18'h0; k++) begin
            if (k > 400) begin abort = 1'b1; break; end
            @(negedge CLK);
          end
          if (abort) break;
          tx_dec = dec9(out_d);
          chk("stress_tx_code", tx_dec[9], 1);
          chk("stress_tx_data", tx_dec[8:0], (tx_q.size() != 0) ? 32'(tx_q.pop_front()) : 32'hDEAD);
          tx_got++;
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          out_e = 1'b0;
          for (int k = 0; out_d !== 18'h0; k++) begin
            if (k > 400) begin abort = 1'b1; break; end
            @(negedge CLK);
          end
          if (abort) break;
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          out_e = 1'b1;
        end
        done_cnt++;
      end
      begin : monitor
        for (int c = 0; c < BUDGET + 1000 && done_cnt < 4; c++) begin
          @(negedge CLK);
          if ((out_d & ~prev_out_d) != 18'h0)
            chk("tx_rail_rise_with_e_low", prev_out_e, 1);
          if (snd_ready === 1'b1)
            chk("snd_ready_with_rails", out_d, 0);
          if (in_e === 1'b1 && prev_in_e === 1'b0)
            chk("in_e_rise_with_buffer_full", prev_rcv_valid, 0);
          prev_out_d = out_d; prev_out_e = out_e;
          prev_in_e = in_e; prev_rcv_valid = rcv_valid;
        end
      end
    join

    chk("stress_timeout", abort, 0);
    chk("stress_rx_count", rx_got, NTOK);
    chk("stress_tx_count", tx_got, NTOK);
    chk("stress_rx_leftover", rx_q.size(), 0);
    chk("stress_tx_leftover", tx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
